// File: rtl/and2_vec_pkg.sv
// and2_vec_pkg: shared FSM states, sweep length and LFSR tap masks for the AND2 vector generator
package and2_vec_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, GAPW, DONE} state_t;
  function automatic int vec_total(input int w);
    return 1 << (2 * w);
  endfunction
  function automatic logic [7:0] lfsr_taps(input int nb);
    return nb == 2 ? 8'h03 : nb == 4 ? 8'h0C : nb == 6 ? 8'h30 : 8'hB8;
  endfunction
endpackage

// File: rtl/and2_vec_idx.sv
// and2_vec_idx: vector index register with load/advance/hold and last-vector flag (LFSR order under AND2_VEC_LFSR_EN)
module and2_vec_idx import and2_vec_pkg::*; #(
  parameter int NB = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          adv,
`ifdef AND2_VEC_LFSR_EN
  input  logic          mode,
`endif
  output logic [NB-1:0] idx,
  output logic          last
);
`ifdef AND2_VEC_LFSR_EN
  localparam logic [NB-1:0] TAPS = NB'(lfsr_taps(NB));
  logic          lfsr;
  logic [NB-1:0] step;
  assign step = (idx >> 1) ^ (idx[0] ? TAPS : '0);
  // the LFSR state that steps back to the seed is the final vector of the sweep
  assign last = lfsr ? (idx != '0 && step == NB'(1)) : &idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx  <= '0;
      lfsr <= 1'b0;
    end else if (load) begin
      idx  <= '0;
      lfsr <= mode;
    end else if (adv) begin
      idx <= lfsr ? (idx == '0 ? NB'(1) : step) : idx + 1'b1;
    end
`else
  assign last = &idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else if (load) idx <= '0;
    else if (adv) idx <= idx + 1'b1;
`endif
endmodule

// File: rtl/and2_vector_gen.sv
// and2_vector_gen: exhaustive (A,B) sweep over valid/ready with optional idle gap; LFSR order via AND2_VEC_LFSR_EN
module and2_vector_gen import and2_vec_pkg::*; #(
  parameter int W   = 2,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         ready_i,
`ifdef AND2_VEC_LFSR_EN
  input  logic         mode_i,
`endif
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic         valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [2*W:0] vec_cnt_o
);
  localparam int CW = 2 * W + 1;
  localparam logic [3:0] GAP_LAST = 4'(GAP > 0 ? GAP - 1 : 0);
  state_t         state, state_nx;
  logic           load, adv, last, gap_end;
  logic [3:0]     gap_cnt;
  logic [2*W-1:0] idx;
  and2_vec_idx #(.NB(2 * W)) u_idx (
    .clk,
    .rst_n,
    .load,
    .adv,
`ifdef AND2_VEC_LFSR_EN
    .mode(mode_i),
`endif
    .idx,
    .last
  );
  assign a_o     = idx[2*W-1:W];
  assign b_o     = idx[W-1:0];
  assign gap_end = gap_cnt == GAP_LAST;
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    unique case (state)
      IDLE: if (start_i) begin
        state_nx = DRIVE;
        load     = 1'b1;
      end
      DRIVE: if (ready_i) begin
        state_nx = last ? DONE : GAP > 0 ? GAPW : DRIVE;
        adv      = !last;
      end
      GAPW: state_nx = gap_end ? DRIVE : GAPW;
      default: state_nx = IDLE;
    endcase
  end
  // status outputs are registered from the next state so they line up with the state flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      gap_cnt   <= '0;
      vec_cnt_o <= '0;
    end else begin
      state     <= state_nx;
      valid_o   <= state_nx == DRIVE;
      busy_o    <= state_nx != IDLE;
      done_o    <= state_nx == DONE;
      gap_cnt   <= state == GAPW ? gap_cnt + 4'd1 : 4'd0;
      vec_cnt_o <= load ? '0 : vec_cnt_o + CW'(state == DRIVE && ready_i);
    end
endmodule

// File: tb/tb_and2_vector_gen.sv
// tb_and2_vector_gen: randomized sweep bench for two generator instances (GAP=0 and GAP=2) against a sweep-level model
module tb_and2_vector_gen;
  localparam int W = 2;
  localparam int N = 1 << (2 * W);
  logic clk = 0, rst_n = 0, start_i = 0, ready_i = 0, mode_i = 0;
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic valid [2], busy [2], done [2];
  logic [2*W:0] cnt [2];
  int checks = 0, failures = 0;
  int gap_of [2] = '{0, 2};
  bit e_busy [2], e_valid [2], e_done [2], e_lfsr [2];
  int e_sent [2], e_gap [2], e_vec [2];
  bit seen [2][N];
  always #5 clk = ~clk;
  and2_vector_gen #(.W(W), .GAP(0)) dut0 (
    .clk, .rst_n, .start_i, .ready_i,
`ifdef AND2_VEC_LFSR_EN
    .mode_i,
`endif
    .a_o(a[0]), .b_o(b[0]), .valid_o(valid[0]), .busy_o(busy[0]), .done_o(done[0]), .vec_cnt_o(cnt[0])
  );
  and2_vector_gen #(.W(W), .GAP(2)) dut2 (
    .clk, .rst_n, .start_i, .ready_i,
`ifdef AND2_VEC_LFSR_EN
    .mode_i,
`endif
    .a_o(a[1]), .b_o(b[1]), .valid_o(valid[1]), .busy_o(busy[1]), .done_o(done[1]), .vec_cnt_o(cnt[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void upd(input int i);
    if (!rst_n) begin
      e_busy[i] = 0; e_valid[i] = 0; e_done[i] = 0; e_sent[i] = 0;
    end else if (e_done[i]) begin
      e_done[i] = 0; e_busy[i] = 0;
    end else if (!e_busy[i]) begin
      if (start_i) begin
        e_busy[i] = 1; e_valid[i] = 1; e_sent[i] = 0; e_vec[i] = 0; e_lfsr[i] = mode_i;
        for (int v = 0; v < N; v++) seen[i][v] = 0;
        seen[i][0] = 1;
      end
    end else if (e_valid[i]) begin
      if (ready_i) begin
        e_sent[i]++;
        if (e_sent[i] == N) begin
          e_valid[i] = 0; e_done[i] = 1;
        end else begin
          e_vec[i] = e_lfsr[i] ? -1 : e_sent[i];
          if (gap_of[i] > 0) begin e_valid[i] = 0; e_gap[i] = gap_of[i]; end
        end
      end
    end else begin
      e_gap[i]--;
      if (e_gap[i] == 0) e_valid[i] = 1;
    end
  endfunction
  task automatic cmp(input int i);
    int v;
    chk($sformatf("valid%0d", i), valid[i], e_valid[i]);
    chk($sformatf("busy%0d", i), busy[i], e_busy[i]);
    chk($sformatf("done%0d", i), done[i], e_done[i]);
    chk($sformatf("cnt%0d", i), cnt[i], e_sent[i]);
    if (e_valid[i]) begin
      v = {a[i], b[i]};
      if (e_vec[i] < 0) begin
        chk($sformatf("dup%0d", i), seen[i][v], 0);
        seen[i][v] = 1;
        e_vec[i] = v;
      end
      chk($sformatf("a%0d", i), a[i], e_vec[i] / (1 << W));
      chk($sformatf("b%0d", i), b[i], e_vec[i] % (1 << W));
      chk($sformatf("y%0d", i), a[i] & b[i], (e_vec[i] / (1 << W)) & (e_vec[i] % (1 << W)));
    end
  endtask
  task automatic zero_chk(input string tag);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s%0d", tag, i), {a[i], b[i], valid[i], busy[i], done[i], cnt[i]}, 0);
  endtask
  task automatic step(input logic s, input logic r, input logic n);
    start_i = s;
    ready_i = r;
    if (!n) begin
      rst_n = 0;
      #1 zero_chk("async_rst");
    end else rst_n = 1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) upd(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) cmp(i);
  endtask
  task automatic drain();
    for (int k = 0; k < 400 && (e_busy[0] || e_busy[1]); k++) step(0, 1, 1);
    chk("drain0", busy[0], 0);
    chk("drain1", busy[1], 0);
  endtask
  initial begin
    int k;
    repeat (2) @(negedge clk);
    zero_chk("reset");
    step(0, 0, 1);
    step(1, 1, 1);
    k = 1;
    while (!done[0] && k < 40) begin step(0, 1, 1); k++; end
    chk("done_cycle", k, N + 1);
    chk("final_cnt", cnt[0], N);
    drain();
    step(1, 1, 1);
    for (k = 0; k < 40 && !(e_valid[0] && e_sent[0] == 6); k++) step(0, 1, 1);
    chk("at_0110", {a[0], b[0]}, 6);
    repeat (3) step(0, 0, 1);
    step(0, 1, 1);
    chk("after_stall", {a[0], b[0]}, 7);
    drain();
    step(1, 1, 1);
    for (k = 0; k < 40 && e_sent[0] != 5; k++) step(0, 1, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(1, 1, 1);
    chk("restart", {a[0], b[0], valid[0]}, 1);
    drain();
    step(1, 1, 1);
    for (k = 0; k < 40 && e_sent[0] != 7; k++) step(0, 1, 1);
    step(1, 1, 1);
    for (k = 0; k < 40 && !e_done[0]; k++) step(0, 1, 1);
    chk("in_done", done[0], 1);
    step(1, 1, 1);
    chk("start_in_done", busy[0], 0);
    drain();
`ifdef AND2_VEC_LFSR_EN
    mode_i = 1;
    step(1, 1, 1);
    mode_i = 0;
    for (k = 0; k < 40 && !done[0]; k++) step(0, 1, 1);
    chk("lfsr_cnt", cnt[0], N);
    drain();
`endif
    for (int n = 0; n < 1500; n++) begin
`ifdef AND2_VEC_LFSR_EN
      mode_i = 1'($urandom_range(0, 1));
`endif
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
    end
    mode_i = 0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
